// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-ported data memory between the fetch
// refill port (read-only) and the data-cache port (read/write). One
// transaction is in flight at a time; ties alternate round-robin.
module dmem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        I_REQ,
  input  logic [11:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [11:0] D_ADDR,
  input  logic [3:0]  D_BE,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic        MEM_CSN,
  output logic        MEM_WEN,
  output logic [11:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_DOUT,
  input  logic [31:0] MEM_DI,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Counter counts remaining ACCESS cycles after the current one.
  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        winner_is_d_q, winner_is_d_d;
  logic        last_is_d_q, last_is_d_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        csn_q, csn_d;
  logic        wen_q, wen_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        grant_d;

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    winner_is_d_d = winner_is_d_q;
    last_is_d_d   = last_is_d_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    csn_d         = csn_q;
    wen_d         = wen_q;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    // D wins when it is alone, or when both ask and I was granted last.
    grant_d       = D_REQ && (!I_REQ || !last_is_d_q);

    case (state_q)
      IDLE: begin
        if (I_REQ || D_REQ) begin
          state_d       = ACCESS;
          cnt_d         = CNT_LOAD;
          winner_is_d_d = grant_d;
          last_is_d_d   = grant_d;
          csn_d         = 1'b0;
          if (grant_d) begin
            addr_d  = D_ADDR;
            we_d    = D_WE;
            be_d    = D_WE ? D_BE : 4'hF;
            wdata_d = D_WDATA;
            wen_d   = !D_WE;
          end else begin
            addr_d  = I_ADDR;
            we_d    = 1'b0;
            be_d    = 4'hF;
            wen_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          csn_d   = 1'b1;
          wen_d   = 1'b1;
          if (winner_is_d_q) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = MEM_DI;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = MEM_DI;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        csn_d   = 1'b1;
        wen_d   = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any access and drops the strobes at once.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      addr_q        <= 12'd0;
      be_q          <= 4'd0;
      wdata_q       <= 32'd0;
      we_q          <= 1'b0;
      winner_is_d_q <= 1'b0;
      last_is_d_q   <= 1'b0;
      i_rdata_q     <= 32'd0;
      d_rdata_q     <= 32'd0;
      csn_q         <= 1'b1;
      wen_q         <= 1'b1;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      winner_is_d_q <= winner_is_d_d;
      last_is_d_q   <= last_is_d_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      csn_q         <= csn_d;
      wen_q         <= wen_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
    end
  end

  assign I_ACK    = i_ack_q;
  assign D_ACK    = d_ack_q;
  assign I_RDATA  = i_rdata_q;
  assign D_RDATA  = d_rdata_q;
  assign MEM_CSN  = csn_q;
  assign MEM_WEN  = wen_q;
  assign MEM_ADDR = addr_q;
  assign MEM_BE   = be_q;
  assign MEM_DOUT = wdata_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory access cycles per transaction (legal 1..8).
REQ-002 SHALL have port CLK  input  1  system clock, all state on posedge.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port I_REQ  input  1  fetch-refill read request, held until I_ACK.
REQ-005 SHALL have port I_ADDR  input  12  fetch word address.
REQ-006 SHALL have port I_ACK  output  1  one-cycle completion pulse to fetch side.
REQ-007 SHALL have port I_RDATA  output  32  fetch read data.
REQ-008 SHALL have port D_REQ  input  1  data-cache request, held until D_ACK.
REQ-009 SHALL have port D_WE  input  1  1 = write, 0 = read.
REQ-010 SHALL have port D_ADDR  input  12  data word address.
REQ-011 SHALL have port D_BE  input  4  byte enables for writes.
REQ-012 SHALL have port D_WDATA  input  32  write data.
REQ-013 SHALL have port D_ACK  output  1  one-cycle completion pulse to data side.
REQ-014 SHALL have port D_RDATA  output  32  data read data.
REQ-015 SHALL have port MEM_CSN  output  1  memory chip select, active-low.
REQ-016 SHALL have port MEM_WEN  output  1  memory write enable, active-low.
REQ-017 SHALL have port MEM_ADDR  output  12  memory word address.
REQ-018 SHALL have port MEM_BE  output  4  memory byte enables.
REQ-019 SHALL have port MEM_DOUT  output  32  memory write data.
REQ-020 SHALL have port MEM_DI  input  32  memory read data.
REQ-021 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, ACCESS, DONE; exactly one transaction in flight.
REQ-023 IDLE: on posedge with I_REQ or D_REQ high SHALL select a winner, latch its addr/we/be/wdata, load cycle counter with MEM_LAT-1, go ACCESS; with no request SHALL stay IDLE.
REQ-024 Arbitration SHALL be round-robin: with both requests pending, grant the side not granted last; with one request pending, grant it; last-grant SHALL be updated on each grant.
REQ-025 ACCESS: MEM_CSN=0, MEM_ADDR/MEM_BE/MEM_DOUT from latched values; MEM_WEN=0 only for D writes; reads drive MEM_BE=4'b1111, MEM_WEN=1.
REQ-026 ACCESS SHALL last exactly MEM_LAT cycles (counter decrements to 0); on the final ACCESS posedge a read SHALL capture MEM_DI into the winner's RDATA register; then go DONE.
REQ-027 DONE: MEM_CSN=1, MEM_WEN=1; winner's ACK=1 for this single cycle; next state IDLE unconditionally.
REQ-028 Latency: request sampled at IDLE edge k -> ACK high during the cycle after edge k+MEM_LAT; back-to-back transactions SHALL have one IDLE cycle between DONE and next ACCESS.
REQ-029 I_RDATA/D_RDATA SHALL hold their value until the next read completion for that side; D writes SHALL NOT modify D_RDATA.
REQ-030 In IDLE and DONE, MEM_CSN=1 and MEM_WEN=1; MEM_ADDR/MEM_BE/MEM_DOUT hold latched values.
REQ-031 A request deasserted before being granted SHALL cause no memory access; a request deasserted after grant SHALL still complete and pulse ACK.
REQ-032 Requests arriving during ACCESS/DONE SHALL wait; none SHALL be lost while held high.
REQ-033 I_ACK and D_ACK SHALL never be high in the same cycle.

Reset
REQ-034 RSTn low SHALL immediately force state IDLE, MEM_CSN=1, MEM_WEN=1, I_ACK=D_ACK=0, BUSY=0, counter 0, latched addr/be/wdata 0, I_RDATA=D_RDATA=0, last-grant=I (D wins first tie).
REQ-035 Reset during ACCESS SHALL abort the transaction with no ACK; MEM_WEN SHALL rise in the same cycle as RSTn falls.
REQ-036 After RSTn rises, first grant SHALL occur no earlier than the first posedge with RSTn high.

Verification
REQ-037 MEM_LAT=2, D read addr 0x010, memory holds 0x12345678 -> MEM_CSN low 2 cycles, D_ACK pulse in 3rd cycle, D_RDATA=0x12345678.
REQ-038 D write addr 0x020, D_BE=4'b0011, D_WDATA=0xAABBCCDD -> MEM_WEN low 2 cycles with MEM_BE=0011, D_ACK pulse, D_RDATA unchanged.
REQ-039 I_REQ and D_REQ asserted together after reset, both held -> D served first, then I; third simultaneous pair served D again only after I.
REQ-040 MEM_LAT=1, I read 0x004 then immediately again 0x008 -> ACK every 3 cycles, one IDLE cycle between transactions, I_RDATA updates each time.
REQ-041 RSTn pulsed low mid-ACCESS of a D write -> MEM_WEN=1 and BUSY=0 immediately, no D_ACK; after release, re-held D_REQ completes normally.
